// File: rtl/expipe_pkg.sv
// Shared execution-pipeline types: ROB index width and the per-register
// status entry bundle used by the register status table.
package expipe_pkg;

  localparam int ROB_IDX_LEN   = 5;
  localparam int REGSTAT_CNT_W = 8;

  typedef struct packed {
    logic [REGSTAT_CNT_W-1:0] cnt;
    logic [ROB_IDX_LEN-1:0]   rob_idx;
  } regstat_cnt_entry_t;

  function automatic logic [REGSTAT_CNT_W-1:0] cnt_max(input int w);
    return REGSTAT_CNT_W'((1 << w) - 1);
  endfunction

endpackage

// File: rtl/regstat_entry.sv
// One architectural register's status: in-flight producer count and the
// ROB entry of the youngest producer.
module regstat_entry
  import expipe_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   inc_i,
  input  logic                   dec_i,
  input  logic [ROB_IDX_LEN-1:0] rob_i,
  output regstat_cnt_entry_t     ent_o,
  output logic                   uflow_o
);

  logic [CNT_W-1:0]       cnt_q;
  logic [ROB_IDX_LEN-1:0] rob_q;
  logic                   cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      rob_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
      rob_q <= '0;
    end else begin
      if (inc_i) begin
        rob_q <= rob_i;
      end
      // issue+commit together is net zero, except from an empty count
      unique case ({inc_i, dec_i})
        2'b10: cnt_q <= cnt_q + CNT_W'(1);
        2'b01: if (!cnt_zero) cnt_q <= cnt_q - CNT_W'(1);
        2'b11: if (cnt_zero) cnt_q <= CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign ent_o.cnt     = REGSTAT_CNT_W'(cnt_q);
  assign ent_o.rob_idx = rob_q;
  assign uflow_o       = dec_i && cnt_zero;

endmodule

// File: rtl/reg_status_mp.sv
// Register status table: tracks in-flight writers per architectural
// register and reports source busy / producer ROB index at issue.
module reg_status_mp
  import expipe_pkg::*;
#(
  parameter  int REG_NUM     = 32,
  parameter  int CNT_W       = 3,
  parameter  int SKIP_X0     = 1,
  localparam int REG_IDX_LEN = $clog2(REG_NUM)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [REG_IDX_LEN-1:0] issue_rd_idx_i,
  input  logic [ROB_IDX_LEN-1:0] issue_rob_idx_i,
  input  logic [REG_IDX_LEN-1:0] issue_rs1_idx_i,
  input  logic [REG_IDX_LEN-1:0] issue_rs2_idx_i,
  output logic                   issue_rs1_busy_o,
  output logic                   issue_rs2_busy_o,
  output logic [ROB_IDX_LEN-1:0] issue_rs1_rob_idx_o,
  output logic [ROB_IDX_LEN-1:0] issue_rs2_rob_idx_o,
  input  logic                   comm_valid_i,
  output logic                   comm_ready_o,
  input  logic [REG_IDX_LEN-1:0] comm_rd_idx_i,
  input  logic [ROB_IDX_LEN-1:0] comm_rob_idx_i,
  output logic                   underflow_o
);

  localparam logic [REGSTAT_CNT_W-1:0] CNT_FULL = cnt_max(CNT_W);

  regstat_cnt_entry_t ent [REG_NUM];
  logic [REG_NUM-1:0] uflow;
  logic               same_rd;
  logic               issue_fire;
  logic               uflow_q;

  // ownership only moves on issue, so the committing ROB index is not needed
  logic unused_comm_rob;
  assign unused_comm_rob = ^comm_rob_idx_i;

  assign same_rd = comm_valid_i && (comm_rd_idx_i == issue_rd_idx_i);

  assign issue_ready_o =
    !((ent[issue_rd_idx_i].cnt == CNT_FULL) && !same_rd);

  assign issue_fire   = issue_valid_i && issue_ready_o;
  assign comm_ready_o = 1'b1;

  for (genvar r = 0; r < REG_NUM; r++) begin : g_ent
    localparam logic TRACK = !((SKIP_X0 != 0) && (r == 0));
    localparam logic [REG_IDX_LEN-1:0] IDX = REG_IDX_LEN'(r);

    logic inc;
    logic dec;

    assign inc = TRACK && issue_fire && (issue_rd_idx_i == IDX);
    assign dec = TRACK && comm_valid_i && (comm_rd_idx_i == IDX);

    regstat_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (flush_i),
      .inc_i   (inc),
      .dec_i   (dec),
      .rob_i   (issue_rob_idx_i),
      .ent_o   (ent[r]),
      .uflow_o (uflow[r])
    );
  end

  assign issue_rs1_busy_o    = (ent[issue_rs1_idx_i].cnt != '0);
  assign issue_rs2_busy_o    = (ent[issue_rs2_idx_i].cnt != '0);
  assign issue_rs1_rob_idx_o = ent[issue_rs1_idx_i].rob_idx;
  assign issue_rs2_rob_idx_o = ent[issue_rs2_idx_i].rob_idx;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      uflow_q <= 1'b0;
    end else if (!flush_i && (|uflow)) begin
      uflow_q <= 1'b1;
    end
  end

  assign underflow_o = uflow_q;

endmodule
